// File: rtl/bullet_engine.sv
// Two-player projectile engine: one bullet per player, spawned on fire and advanced once per frame tick.
// Resolves boundary exits, bullet-on-player hits (one-cycle collide pulses) and head-on annihilation.
module bullet_engine #(
   parameter int COORD_W         = 10,
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int PLAYER_SIZE     = 16,
   parameter int BULLET_SIZE     = 4,
   parameter int BULLET_SPEED    = 4,
   parameter int COOLDOWN_FRAMES = 15
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               frame_tick_i,
   input  logic               enable_i,
   input  logic               clear_i,
   input  logic               fire_p1_i,
   input  logic               fire_p2_i,
   input  logic [COORD_W-1:0] p1_x_i,
   input  logic [COORD_W-1:0] p1_y_i,
   input  logic [COORD_W-1:0] p2_x_i,
   input  logic [COORD_W-1:0] p2_y_i,
   input  logic [1:0]         p1_dir_i,
   input  logic [1:0]         p2_dir_i,
   output logic [COORD_W-1:0] b1_x_o,
   output logic [COORD_W-1:0] b1_y_o,
   output logic [COORD_W-1:0] b2_x_o,
   output logic [COORD_W-1:0] b2_y_o,
   output logic               b1_active_o,
   output logic               b2_active_o,
   output logic               bullet_collide_player_1_o,
   output logic               bullet_collide_player_2_o
);

   localparam int W1   = COORD_W + 1;
   localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_FLY  = 1'b1;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam logic [W1-1:0]      PS      = W1'(PLAYER_SIZE);
   localparam logic [W1-1:0]      BS      = W1'(BULLET_SIZE);
   localparam logic [W1-1:0]      SPD     = W1'(BULLET_SPEED);
   localparam logic [W1-1:0]      SW      = W1'(SCREEN_W);
   localparam logic [W1-1:0]      SH      = W1'(SCREEN_H);
   localparam logic [W1-1:0]      OFF     = W1'(PLAYER_SIZE / 2 - BULLET_SIZE / 2);
   localparam logic [COORD_W-1:0] SPD_C   = COORD_W'(BULLET_SPEED);
   localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN_FRAMES);
   localparam logic [CD_W-1:0]    CD_ONE  = CD_W'(1);

   typedef struct packed {
      logic [0:0]         st;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [1:0]         dir;
      logic [CD_W-1:0]    cd;
      logic               hit;
   } bullet_t;

   bullet_t b1_q, b2_q, b1_d, b2_d;

   function automatic logic overlap(input logic [W1-1:0] ax, input logic [W1-1:0] ay,
                                    input logic [W1-1:0] asz, input logic [W1-1:0] bx,
                                    input logic [W1-1:0] by, input logic [W1-1:0] bsz);
      return (ax < bx + bsz) && (ax + asz > bx) && (ay < by + bsz) && (ay + asz > by);
   endfunction

   // One tick of a single bullet: spawn or move, then the hit test against the opponent.
   function automatic bullet_t bullet_step(input bullet_t b, input logic fire,
                                           input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                           input logic [1:0] pdir,
                                           input logic [COORD_W-1:0] ox, input logic [COORD_W-1:0] oy);
      bullet_t       n;
      logic          live;
      logic [W1-1:0] x1;
      logic [W1-1:0] y1;
      n     = b;
      n.hit = 1'b0;
      live  = 1'b0;
      x1    = {1'b0, b.x};
      y1    = {1'b0, b.y};
      n.cd  = (b.cd != '0) ? b.cd - CD_ONE : b.cd;
      if (b.st == S_IDLE) begin
         if (fire && b.cd == '0) begin
            n.x   = COORD_W'({1'b0, px} + OFF);
            n.y   = COORD_W'({1'b0, py} + OFF);
            n.dir = pdir;
            n.cd  = CD_LOAD;
            live  = 1'b1;
         end
      end else begin
         case (b.dir)
            DIR_UP:    if (y1 >= SPD)           begin n.y = b.y - SPD_C; live = 1'b1; end
            DIR_RIGHT: if (x1 + SPD + BS <= SW) begin n.x = b.x + SPD_C; live = 1'b1; end
            DIR_DOWN:  if (y1 + SPD + BS <= SH) begin n.y = b.y + SPD_C; live = 1'b1; end
            DIR_LEFT:  if (x1 >= SPD)           begin n.x = b.x - SPD_C; live = 1'b1; end
         endcase
      end
      if (live && overlap({1'b0, n.x}, {1'b0, n.y}, BS, {1'b0, ox}, {1'b0, oy}, PS)) begin
         live  = 1'b0;
         n.hit = 1'b1;
      end
      n.st = live ? S_FLY : S_IDLE;
      return n;
   endfunction

   always_comb begin
      b1_d = bullet_step(b1_q, fire_p1_i, p1_x_i, p1_y_i, p1_dir_i, p2_x_i, p2_y_i);
      b2_d = bullet_step(b2_q, fire_p2_i, p2_x_i, p2_y_i, p2_dir_i, p1_x_i, p1_y_i);
      if (b1_d.st == S_FLY && b2_d.st == S_FLY &&
          overlap({1'b0, b1_d.x}, {1'b0, b1_d.y}, BS, {1'b0, b2_d.x}, {1'b0, b2_d.y}, BS)) begin
         b1_d.st = S_IDLE;
         b2_d.st = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         b1_q <= '0;
         b2_q <= '0;
      end else if (clear_i || !enable_i) begin
         b1_q <= '0;
         b2_q <= '0;
      end else if (frame_tick_i) begin
         b1_q <= b1_d;
         b2_q <= b2_d;
      end else begin
         // collide pulses last exactly one cycle after the tick edge
         b1_q.hit <= 1'b0;
         b2_q.hit <= 1'b0;
      end
   end

   assign b1_x_o                    = b1_q.x;
   assign b1_y_o                    = b1_q.y;
   assign b2_x_o                    = b2_q.x;
   assign b2_y_o                    = b2_q.y;
   assign b1_active_o               = (b1_q.st == S_FLY);
   assign b2_active_o               = (b2_q.st == S_FLY);
   assign bullet_collide_player_2_o = b1_q.hit;
   assign bullet_collide_player_1_o = b2_q.hit;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: expected outputs are queued as stimulus is applied and checked after each edge.
module tb_bullet_engine;

   logic       clk = 1'b0;
   logic       clk_en = 1'b1;
   logic       reset_ni, frame_tick_i, enable_i, clear_i, fire_p1_i, fire_p2_i;
   logic [9:0] p1_x_i, p1_y_i, p2_x_i, p2_y_i;
   logic [1:0] p1_dir_i, p2_dir_i;
   logic [9:0] b1_x_o, b1_y_o, b2_x_o, b2_y_o;
   logic       b1_active_o, b2_active_o, bullet_collide_player_1_o, bullet_collide_player_2_o;

   always #5 if (clk_en) clk = ~clk;

   bullet_engine dut (
      .clk_i                     (clk),
      .reset_ni                  (reset_ni),
      .frame_tick_i              (frame_tick_i),
      .enable_i                  (enable_i),
      .clear_i                   (clear_i),
      .fire_p1_i                 (fire_p1_i),
      .fire_p2_i                 (fire_p2_i),
      .p1_x_i                    (p1_x_i),
      .p1_y_i                    (p1_y_i),
      .p2_x_i                    (p2_x_i),
      .p2_y_i                    (p2_y_i),
      .p1_dir_i                  (p1_dir_i),
      .p2_dir_i                  (p2_dir_i),
      .b1_x_o                    (b1_x_o),
      .b1_y_o                    (b1_y_o),
      .b2_x_o                    (b2_x_o),
      .b2_y_o                    (b2_y_o),
      .b1_active_o               (b1_active_o),
      .b2_active_o               (b2_active_o),
      .bullet_collide_player_1_o (bullet_collide_player_1_o),
      .bullet_collide_player_2_o (bullet_collide_player_2_o)
   );

   typedef struct {
      int b1x, b1y, b1a, b2x, b2y, b2a, c1, c2;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int b1x, b1y, b1a, b2x, b2y, b2a, c1, c2);
      exp_t e;
      e.b1x = b1x; e.b1y = b1y; e.b1a = b1a;
      e.b2x = b2x; e.b2y = b2y; e.b2a = b2a;
      e.c1  = c1;  e.c2  = c2;
      sb.push_back(e);
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({tag, ".b1x"}, 32'(b1_x_o), e.b1x);
      check({tag, ".b1y"}, 32'(b1_y_o), e.b1y);
      check({tag, ".b1a"}, 32'(b1_active_o), e.b1a);
      check({tag, ".b2x"}, 32'(b2_x_o), e.b2x);
      check({tag, ".b2y"}, 32'(b2_y_o), e.b2y);
      check({tag, ".b2a"}, 32'(b2_active_o), e.b2a);
      check({tag, ".col1"}, 32'(bullet_collide_player_1_o), e.c1);
      check({tag, ".col2"}, 32'(bullet_collide_player_2_o), e.c2);
   endtask

   // One clock with frame_tick_i = tick; the expectation for the edge is queued first.
   task automatic step(input string tag, input logic tick,
                       input int b1x, b1y, b1a, b2x, b2y, b2a, c1, c2);
      push(b1x, b1y, b1a, b2x, b2y, b2a, c1, c2);
      @(negedge clk);
      frame_tick_i = tick;
      @(posedge clk);
      #1;
      frame_tick_i = 1'b0;
      compare(tag);
   endtask

   task automatic do_clear(input string tag);
      clear_i = 1'b1;
      step(tag, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      clear_i = 1'b0;
   endtask

   initial begin
      reset_ni = 1'b0; frame_tick_i = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
      fire_p1_i = 1'b0; fire_p2_i = 1'b0;
      p1_x_i = 10'd100; p1_y_i = 10'd200; p1_dir_i = 2'd1;
      p2_x_i = 10'd300; p2_y_i = 10'd200; p2_dir_i = 2'd0;
      #3;
      push(0, 0, 0, 0, 0, 0, 0, 0);
      compare("reset");
      #20;
      @(negedge clk);
      reset_ni = 1'b1;

      // P1 shoots right into P2: 48th move reaches x=298 and hits
      fire_p1_i = 1'b1;
      step("hit.spawn", 1'b1, 106, 206, 1, 0, 0, 0, 0, 0);
      fire_p1_i = 1'b0;
      for (int k = 1; k <= 47; k++)
         step($sformatf("hit.m%0d", k), 1'b1, 106 + 4 * k, 206, 1, 0, 0, 0, 0, 0);
      step("hit.m48", 1'b1, 298, 206, 0, 0, 0, 0, 0, 1);
      step("hit.pulse_end", 1'b0, 298, 206, 0, 0, 0, 0, 0, 0);
      step("hit.idle_tick", 1'b1, 298, 206, 0, 0, 0, 0, 0, 0);
      do_clear("hit.clear");

      // Right edge exit for P1, left edge exit for P2
      p1_x_i = 10'd620; p1_y_i = 10'd100; p1_dir_i = 2'd1;
      fire_p1_i = 1'b1;
      step("bnd_r.spawn", 1'b1, 626, 106, 1, 0, 0, 0, 0, 0);
      fire_p1_i = 1'b0;
      step("bnd_r.m1", 1'b1, 630, 106, 1, 0, 0, 0, 0, 0);
      step("bnd_r.m2", 1'b1, 634, 106, 1, 0, 0, 0, 0, 0);
      step("bnd_r.exit", 1'b1, 634, 106, 0, 0, 0, 0, 0, 0);
      p2_x_i = 10'd0; p2_y_i = 10'd50; p2_dir_i = 2'd3;
      fire_p2_i = 1'b1;
      step("bnd_l.spawn", 1'b1, 634, 106, 0, 6, 56, 1, 0, 0);
      fire_p2_i = 1'b0;
      step("bnd_l.m1", 1'b1, 634, 106, 0, 2, 56, 1, 0, 0);
      step("bnd_l.exit", 1'b1, 634, 106, 0, 2, 56, 0, 0, 0);
      do_clear("bnd.clear");

      // Cooldown: spawn loads 15, which counts down over the next 15 ticks; the tick after that re-fires
      p2_x_i = 10'd300; p2_y_i = 10'd200; p2_dir_i = 2'd0;
      fire_p1_i = 1'b1;
      step("cd.spawn", 1'b1, 626, 106, 1, 0, 0, 0, 0, 0);
      step("cd.m1", 1'b1, 630, 106, 1, 0, 0, 0, 0, 0);
      step("cd.m2", 1'b1, 634, 106, 1, 0, 0, 0, 0, 0);
      for (int k = 3; k <= 15; k++)
         step($sformatf("cd.t%0d", k), 1'b1, 634, 106, 0, 0, 0, 0, 0, 0);
      step("cd.respawn", 1'b1, 626, 106, 1, 0, 0, 0, 0, 0);
      fire_p1_i = 1'b0;
      do_clear("cd.clear");

      // Simultaneous hits with rows 8 pixels apart
      p1_x_i = 10'd100; p1_y_i = 10'd200; p1_dir_i = 2'd1;
      p2_x_i = 10'd300; p2_y_i = 10'd208; p2_dir_i = 2'd3;
      fire_p1_i = 1'b1; fire_p2_i = 1'b1;
      step("sim.spawn", 1'b1, 106, 206, 1, 306, 214, 1, 0, 0);
      fire_p1_i = 1'b0; fire_p2_i = 1'b0;
      for (int k = 1; k <= 47; k++)
         step($sformatf("sim.m%0d", k), 1'b1, 106 + 4 * k, 206, 1, 306 - 4 * k, 214, 1, 0, 0);
      step("sim.hit", 1'b1, 298, 206, 0, 114, 214, 0, 1, 1);
      step("sim.pulse_end", 1'b0, 298, 206, 0, 114, 214, 0, 0, 0);
      do_clear("sim.clear");

      // Head-on on the same row: bullets meet at x=206 and vanish without pulses
      p2_y_i = 10'd200;
      fire_p1_i = 1'b1; fire_p2_i = 1'b1;
      step("ann.spawn", 1'b1, 106, 206, 1, 306, 206, 1, 0, 0);
      fire_p1_i = 1'b0; fire_p2_i = 1'b0;
      for (int k = 1; k <= 24; k++)
         step($sformatf("ann.m%0d", k), 1'b1, 106 + 4 * k, 206, 1, 306 - 4 * k, 206, 1, 0, 0);
      step("ann.meet", 1'b1, 206, 206, 0, 206, 206, 0, 0, 0);

      // Gating by enable_i and clear_i
      fire_p1_i = 1'b1; fire_p2_i = 1'b1;
      step("gate.spawn", 1'b1, 106, 206, 1, 306, 206, 1, 0, 0);
      fire_p1_i = 1'b0; fire_p2_i = 1'b0;
      step("gate.m1", 1'b1, 110, 206, 1, 302, 206, 1, 0, 0);
      enable_i = 1'b0;
      step("gate.disable", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      fire_p1_i = 1'b1; fire_p2_i = 1'b1;
      step("gate.fire_disabled", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      enable_i = 1'b1;
      step("gate.cd_cleared", 1'b1, 106, 206, 1, 306, 206, 1, 0, 0);
      fire_p1_i = 1'b0; fire_p2_i = 1'b0;
      step("gate.m2", 1'b1, 110, 206, 1, 302, 206, 1, 0, 0);
      clear_i = 1'b1;
      step("gate.clear_over_tick", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      clear_i = 1'b0;
      fire_p1_i = 1'b1; fire_p2_i = 1'b1;
      step("gate.respawn", 1'b1, 106, 206, 1, 306, 206, 1, 0, 0);
      fire_p1_i = 1'b0; fire_p2_i = 1'b0;

      // Asynchronous reset mid-flight with the clock stopped
      @(negedge clk);
      clk_en = 1'b0;
      #2;
      reset_ni = 1'b0;
      #1;
      push(0, 0, 0, 0, 0, 0, 0, 0);
      compare("areset");
      #5;
      reset_ni = 1'b1;
      clk_en = 1'b1;
      fire_p1_i = 1'b1;
      step("areset.spawn", 1'b1, 106, 206, 1, 0, 0, 0, 0, 0);
      fire_p1_i = 1'b0;
      step("areset.m1", 1'b1, 110, 206, 1, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
